// File: rtl/pipeline_pkg.sv
// Shared types and constants for the decode-side hazard/forwarding controller.
package pipeline_pkg;

  // Shadow entries carry rd at a fixed maximum width; narrower indices are zero-extended.
  localparam int RD_MAX_W    = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic                v;
    logic                wr;
    logic [RD_MAX_W-1:0] rd;
    logic                ld;
  } shadow_entry_t;

  localparam shadow_entry_t BUBBLE = '0;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-operand priority match over the shadow pipeline: youngest matching writer wins.
module hazard_match
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int PIPE_DEPTH       = 3,
  parameter int LOAD_READY_STAGE = 2,
  parameter int ZERO_REG_EN      = 1,
  parameter int SELW             = 2
) (
  input  shadow_entry_t [PIPE_DEPTH:1] i_entries,
  input  logic [REG_ADDR_WIDTH-1:0]    i_rs,
  input  logic                         i_used,
  output logic                         o_hazard,
  output logic [SELW-1:0]              o_sel
);

  logic                  w_zero;
  logic [PIPE_DEPTH:1]   w_hit;
  logic                  w_found;

  assign w_zero = (ZERO_REG_EN != 0) && (i_rs == '0);

  always_comb begin
    w_hit = '0;
    for (int k = 1; k <= PIPE_DEPTH; k++) begin
      w_hit[k] = i_entries[k].v && i_entries[k].wr && i_used && !w_zero &&
                 (i_entries[k].rd == RD_MAX_W'(i_rs));
    end
  end

  // Scan youngest first; the first hit decides between stall and forward.
  always_comb begin
    o_sel    = SELW'(FWD_REGFILE);
    o_hazard = 1'b0;
    w_found  = 1'b0;
    for (int k = 1; k <= PIPE_DEPTH; k++) begin
      if (w_hit[k] && !w_found) begin
        w_found = 1'b1;
        if (i_entries[k].ld && (k < LOAD_READY_STAGE)) begin
          o_hazard = 1'b1;
        end else begin
          o_sel = SELW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard detection and forwarding select for decode, backed by a shadow pipeline
// of in-flight register writes plus saturating stall/forward counters.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int PIPE_DEPTH       = 3,
  parameter int LOAD_READY_STAGE = 2,
  parameter int ZERO_REG_EN      = 1,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             id_valid,
  input  logic [REG_ADDR_WIDTH-1:0]        id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0]        id_rs2,
  input  logic                             id_rs1_used,
  input  logic                             id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0]        id_rd,
  input  logic                             id_wr_en,
  input  logic                             id_is_load,
  input  logic                             flush,
  input  logic                             hold,
  output logic                             id_stall,
  output logic                             id_accept,
  output logic [sel_w(PIPE_DEPTH)-1:0]     fwd_sel1,
  output logic [sel_w(PIPE_DEPTH)-1:0]     fwd_sel2,
  output logic [CNT_WIDTH-1:0]             stall_cnt,
  output logic [CNT_WIDTH-1:0]             fwd_cnt
);

  localparam int SELW = sel_w(PIPE_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  shadow_entry_t [PIPE_DEPTH:1] r_shadow;
  logic [CNT_WIDTH-1:0]         r_stall_cnt;
  logic [CNT_WIDTH-1:0]         r_fwd_cnt;

  logic                w_haz1, w_haz2;
  logic [SELW-1:0]     w_sel1, w_sel2;
  logic                w_stall_inc, w_fwd_inc;
  shadow_entry_t       w_new;

  hazard_match #(
    .REG_ADDR_WIDTH  (REG_ADDR_WIDTH),
    .PIPE_DEPTH      (PIPE_DEPTH),
    .LOAD_READY_STAGE(LOAD_READY_STAGE),
    .ZERO_REG_EN     (ZERO_REG_EN),
    .SELW            (SELW)
  ) u_match_rs1 (
    .i_entries(r_shadow),
    .i_rs     (id_rs1),
    .i_used   (id_rs1_used),
    .o_hazard (w_haz1),
    .o_sel    (w_sel1)
  );

  hazard_match #(
    .REG_ADDR_WIDTH  (REG_ADDR_WIDTH),
    .PIPE_DEPTH      (PIPE_DEPTH),
    .LOAD_READY_STAGE(LOAD_READY_STAGE),
    .ZERO_REG_EN     (ZERO_REG_EN),
    .SELW            (SELW)
  ) u_match_rs2 (
    .i_entries(r_shadow),
    .i_rs     (id_rs2),
    .i_used   (id_rs2_used),
    .o_hazard (w_haz2),
    .o_sel    (w_sel2)
  );

  // Stall is independent of hold/flush so decode sees the true dependency state.
  assign id_stall  = id_valid & (w_haz1 | w_haz2);
  assign id_accept = id_valid & ~id_stall & ~hold & ~flush;
  assign fwd_sel1  = w_sel1;
  assign fwd_sel2  = w_sel2;
  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;

  assign w_stall_inc = id_valid & id_stall & ~hold;
  assign w_fwd_inc   = id_accept & ((|w_sel1) | (|w_sel2));

  always_comb begin
    w_new    = BUBBLE;
    w_new.v  = 1'b1;
    w_new.wr = id_wr_en;
    w_new.rd = RD_MAX_W'(id_rd);
    w_new.ld = id_is_load;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shadow <= '0;
    end else if (!hold) begin
      r_shadow[1] <= id_accept ? w_new : BUBBLE;
      for (int k = 2; k <= PIPE_DEPTH; k++) begin
        r_shadow[k] <= r_shadow[k-1];
      end
      // The EX instruction is squashed on its way into stage 2.
      if (flush) begin
        r_shadow[2] <= BUBBLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (w_fwd_inc && (r_fwd_cnt != '1)) begin
        r_fwd_cnt <= r_fwd_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// against an in-flight-instruction reference model.
module tb_pipeline_hazard_ctrl;

  localparam int RW  = 5;
  localparam int D   = 3;
  localparam int LRS = 2;
  localparam int CW  = 16;
  localparam int SW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_valid = 1'b0, id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic id_wr_en = 1'b0, id_is_load = 1'b0, flush = 1'b0, hold = 1'b0;
  logic [RW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;

  logic          id_stall, id_accept;
  logic [SW-1:0] fwd_sel1, fwd_sel2;
  logic [CW-1:0] stall_cnt, fwd_cnt;

  logic          id_stall_c2, id_accept_c2;
  logic [SW-1:0] fwd_sel1_c2, fwd_sel2_c2;
  logic [1:0]    stall_cnt_c2, fwd_cnt_c2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush), .hold(hold),
    .id_stall(id_stall), .id_accept(id_accept), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  pipeline_hazard_ctrl #(.CNT_WIDTH(2)) dut_c2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush), .hold(hold),
    .id_stall(id_stall_c2), .id_accept(id_accept_c2), .fwd_sel1(fwd_sel1_c2),
    .fwd_sel2(fwd_sel2_c2), .stall_cnt(stall_cnt_c2), .fwd_cnt(fwd_cnt_c2)
  );

  // Reference model: which instruction sits how many stages past decode.
  bit m_v [1:D];
  bit m_wr[1:D];
  int m_rd[1:D];
  bit m_ld[1:D];
  int m_scnt, m_fcnt, m_scnt2, m_fcnt2;
  int exp_sel1, exp_sel2;
  bit exp_haz1, exp_haz2, exp_stall, exp_accept;

  function automatic void model_reset();
    for (int k = 1; k <= D; k++) begin
      m_v[k] = 0; m_wr[k] = 0; m_rd[k] = 0; m_ld[k] = 0;
    end
    m_scnt = 0; m_fcnt = 0; m_scnt2 = 0; m_fcnt2 = 0;
  endfunction

  function automatic void lookup(input int r, input bit used, output int sel, output bit haz);
    sel = 0; haz = 0;
    if (!used || r == 0) return;
    for (int k = 1; k <= D; k++) begin
      if (m_v[k] && m_wr[k] && m_rd[k] == r) begin
        if (m_ld[k] && k < LRS) haz = 1;
        else sel = k;
        return;
      end
    end
  endfunction

  function automatic void model_eval();
    lookup(int'(id_rs1), id_rs1_used, exp_sel1, exp_haz1);
    lookup(int'(id_rs2), id_rs2_used, exp_sel2, exp_haz2);
    exp_stall  = id_valid && (exp_haz1 || exp_haz2);
    exp_accept = id_valid && !exp_stall && !hold && !flush;
  endfunction

  function automatic void model_update();
    if (exp_stall && !hold) begin
      if (m_scnt  < 65535) m_scnt++;
      if (m_scnt2 < 3)     m_scnt2++;
    end
    if (exp_accept && (exp_sel1 != 0 || exp_sel2 != 0)) begin
      if (m_fcnt  < 65535) m_fcnt++;
      if (m_fcnt2 < 3)     m_fcnt2++;
    end
    if (!hold) begin
      for (int k = D; k >= 2; k--) begin
        m_v[k] = m_v[k-1]; m_wr[k] = m_wr[k-1]; m_rd[k] = m_rd[k-1]; m_ld[k] = m_ld[k-1];
      end
      m_v[1] = exp_accept; m_wr[1] = exp_accept && id_wr_en;
      m_rd[1] = exp_accept ? int'(id_rd) : 0; m_ld[1] = exp_accept && id_is_load;
      if (flush) begin
        m_v[2] = 0; m_wr[2] = 0; m_rd[2] = 0; m_ld[2] = 0;
      end
    end
  endfunction

  task automatic set_in(input bit v, input int a1, input bit u1, input int a2, input bit u2,
                        input int rd, input bit wr, input bit ld, input bit fl, input bit hd);
    id_valid = v; id_rs1 = RW'(a1); id_rs1_used = u1; id_rs2 = RW'(a2); id_rs2_used = u2;
    id_rd = RW'(rd); id_wr_en = wr; id_is_load = ld; flush = fl; hold = hd;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_update();
    #1;
  endtask

  task automatic idle();      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic alu(int rd); set_in(1, 0, 0, 0, 0, rd, 1, 0, 0, 0); endtask
  task automatic ld(int rd);  set_in(1, 0, 0, 0, 0, rd, 1, 1, 0, 0); endtask
  task automatic use1(int r); set_in(1, r, 1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic use2(int r); set_in(1, 0, 0, r, 1, 0, 0, 0, 0, 0); endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    idle();
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    set_in(1, 3, 1, 4, 1, 0, 0, 0, 0, 0);
    n_tests++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b want 0", id_stall); end
    n_tests++; if (id_accept !== 1'b1) begin n_fail++; $display("FAIL reset_accept got %0b want 1", id_accept); end
    n_tests++; if (fwd_sel1 !== 2'd0 || fwd_sel2 !== 2'd0) begin n_fail++; $display("FAIL reset_sel got %0d/%0d want 0/0", fwd_sel1, fwd_sel2); end
    n_tests++; if (stall_cnt !== 16'd0 || fwd_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, fwd_cnt); end
    set_in(1, 3, 1, 4, 1, 0, 0, 0, 0, 1);
    n_tests++; if (id_accept !== 1'b0) begin n_fail++; $display("FAIL reset_accept_hold got %0b want 0", id_accept); end
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic test_alu_chain();
    do_reset();
    alu(3); tick();
    set_in(1, 3, 1, 0, 0, 6, 1, 0, 0, 0);
    n_tests++; if (fwd_sel1 !== 2'd1) begin n_fail++; $display("FAIL alu_sel1 got %0d want 1", fwd_sel1); end
    n_tests++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall got %0b want 0", id_stall); end
    tick();
    n_tests++; if (fwd_cnt !== 16'd1) begin n_fail++; $display("FAIL alu_fwd_cnt got %0d want 1", fwd_cnt); end
  endtask

  task automatic test_load_use();
    do_reset();
    ld(5); tick();
    use2(5);
    n_tests++; if (id_stall !== 1'b1 || id_accept !== 1'b0) begin n_fail++; $display("FAIL ldu_stall got %0b/%0b want 1/0", id_stall, id_accept); end
    tick(); use2(5);
    n_tests++; if (id_stall !== 1'b0 || fwd_sel2 !== 2'd2) begin n_fail++; $display("FAIL ldu_fwd got stall %0b sel2 %0d want 0/2", id_stall, fwd_sel2); end
    n_tests++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL ldu_stall_cnt got %0d want 1", stall_cnt); end
  endtask

  task automatic test_wb_forward();
    do_reset();
    alu(7); tick(); idle(); tick(); idle(); tick();
    use1(7);
    n_tests++; if (fwd_sel1 !== 2'd3) begin n_fail++; $display("FAIL wb_sel1 got %0d want 3", fwd_sel1); end
    tick(); use1(7);
    n_tests++; if (fwd_sel1 !== 2'd0) begin n_fail++; $display("FAIL wb_gone_sel1 got %0d want 0", fwd_sel1); end
  endtask

  task automatic test_priority_zero();
    do_reset();
    alu(4); tick(); ld(4); tick(); alu(4); tick();
    set_in(1, 4, 1, 4, 1, 0, 0, 0, 0, 0);
    n_tests++; if (fwd_sel1 !== 2'd1 || fwd_sel2 !== 2'd1) begin n_fail++; $display("FAIL prio_sel got %0d/%0d want 1/1", fwd_sel1, fwd_sel2); end
    tick();
    ld(0); tick();
    set_in(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    n_tests++; if (fwd_sel1 !== 2'd0 || fwd_sel2 !== 2'd0 || id_stall !== 1'b0) begin
      n_fail++; $display("FAIL zero_reg got sel %0d/%0d stall %0b want 0/0/0", fwd_sel1, fwd_sel2, id_stall); end
  endtask

  task automatic test_hold_flush();
    do_reset();
    ld(9); tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 9, 1, 0, 0, 0, 0, 0, 0, 1);
      n_tests++; if (id_accept !== 1'b0 || id_stall !== 1'b1) begin n_fail++; $display("FAIL hold_%0d got acc %0b stall %0b want 0/1", i, id_accept, id_stall); end
      tick();
    end
    n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL hold_stall_cnt got %0d want 0", stall_cnt); end
    use1(9);
    n_tests++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL hold_frozen got %0b want 1", id_stall); end
    tick();
    n_tests++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL hold_release_cnt got %0d want 1", stall_cnt); end
    alu(10); tick();
    set_in(1, 10, 1, 0, 0, 0, 0, 0, 1, 0);
    n_tests++; if (id_accept !== 1'b0) begin n_fail++; $display("FAIL flush_accept got %0b want 0", id_accept); end
    tick(); use1(10);
    n_tests++; if (fwd_sel1 !== 2'd0) begin n_fail++; $display("FAIL flush_sel1 got %0d want 0", fwd_sel1); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ld(11 + i); tick();
      use1(11 + i); tick();
      use1(11 + i); tick();
    end
    n_tests++; if (stall_cnt_c2 !== 2'd3 || fwd_cnt_c2 !== 2'd3) begin n_fail++; $display("FAIL sat_c2 got %0d/%0d want 3/3", stall_cnt_c2, fwd_cnt_c2); end
    n_tests++; if (stall_cnt !== 16'd5 || fwd_cnt !== 16'd5) begin n_fail++; $display("FAIL sat_c16 got %0d/%0d want 5/5", stall_cnt, fwd_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ld(5); tick(); use2(5); tick(); use2(5); tick();
    ld(6); tick(); use1(6);
    n_tests++; if (id_stall !== 1'b1 || stall_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_pre got stall %0b cnt %0d want 1/1", id_stall, stall_cnt); end
    rst = 1'b0;
    #1;
    n_tests++; if (id_stall !== 1'b0 || id_accept !== 1'b1) begin n_fail++; $display("FAIL mid_rst_out got stall %0b acc %0b want 0/1", id_stall, id_accept); end
    n_tests++; if (stall_cnt !== 16'd0 || fwd_cnt !== 16'd0 || fwd_sel1 !== 2'd0) begin
      n_fail++; $display("FAIL mid_rst_state got cnt %0d/%0d sel1 %0d want 0/0/0", stall_cnt, fwd_cnt, fwd_sel1); end
    model_reset();
    idle(); tick();
    rst = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1) == 1,
             $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 3),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      n_tests++; if (id_stall !== exp_stall || id_stall_c2 !== exp_stall) begin
        n_fail++; $display("FAIL rnd_stall c%0d got %0b/%0b want %0b", c, id_stall, id_stall_c2, exp_stall); end
      n_tests++; if (id_accept !== exp_accept || id_accept_c2 !== exp_accept) begin
        n_fail++; $display("FAIL rnd_accept c%0d got %0b/%0b want %0b", c, id_accept, id_accept_c2, exp_accept); end
      n_tests++; if (fwd_sel1 !== SW'(exp_sel1) || fwd_sel1_c2 !== SW'(exp_sel1)) begin
        n_fail++; $display("FAIL rnd_sel1 c%0d got %0d/%0d want %0d", c, fwd_sel1, fwd_sel1_c2, exp_sel1); end
      n_tests++; if (fwd_sel2 !== SW'(exp_sel2) || fwd_sel2_c2 !== SW'(exp_sel2)) begin
        n_fail++; $display("FAIL rnd_sel2 c%0d got %0d/%0d want %0d", c, fwd_sel2, fwd_sel2_c2, exp_sel2); end
      n_tests++; if (stall_cnt !== CW'(m_scnt) || fwd_cnt !== CW'(m_fcnt)) begin
        n_fail++; $display("FAIL rnd_cnt c%0d got %0d/%0d want %0d/%0d", c, stall_cnt, fwd_cnt, m_scnt, m_fcnt); end
      n_tests++; if (stall_cnt_c2 !== 2'(m_scnt2) || fwd_cnt_c2 !== 2'(m_fcnt2)) begin
        n_fail++; $display("FAIL rnd_cnt_c2 c%0d got %0d/%0d want %0d/%0d", c, stall_cnt_c2, fwd_cnt_c2, m_scnt2, m_fcnt2); end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout bench did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_wb_forward();
    test_priority_zero();
    test_hold_flush();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard-detection and forwarding controller for the pipelined core. It sits beside the decode stage and tracks every in-flight register write in a shadow pipeline of `PIPE_DEPTH` stages. Each cycle it tells decode whether to stall and, per source operand, which stage result to forward. This adds load-use stalls, flushes, downstream hold and performance counters to the fixed 4-stage datapath.

## Interface
Parameters:
- `REG_ADDR_WIDTH`, 5: register index width.
- `PIPE_DEPTH`, 3: number of stages after decode. Stage 1 = EX, stage `PIPE_DEPTH` = writeback. Legal range 2..7.
- `LOAD_READY_STAGE`, 2: first stage at which a load result can be forwarded. Range 2..`PIPE_DEPTH`.
- `ZERO_REG_EN`, 1: when 1, register 0 never creates a hazard or a forward.
- `CNT_WIDTH`, 16: width of the performance counters.

Ports (`SELW` = clog2(`PIPE_DEPTH`+1)):
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  decode holds an instruction.
- `id_rs1`, `id_rs2`  in  `REG_ADDR_WIDTH`  source register indices.
- `id_rs1_used`, `id_rs2_used`  in  1  the operand is actually read.
- `id_rd`  in  `REG_ADDR_WIDTH`  destination register.
- `id_wr_en`  in  1  the instruction writes `id_rd`.
- `id_is_load`  in  1  the result comes from dmem.
- `flush`  in  1  squash the decode and EX instructions.
- `hold`  in  1  downstream freeze; nothing advances.
- `id_stall`  out  1  decode must not issue.
- `id_accept`  out  1  the instruction leaves decode this cycle.
- `fwd_sel1`, `fwd_sel2`  out  `SELW`  0 = regfile, k = result of stage k.
- `stall_cnt`, `fwd_cnt`  out  `CNT_WIDTH`  saturating performance counters.

## Operation
- Shadow entry k (1..`PIPE_DEPTH`) holds {v, wr, rd, ld}. A bubble has all fields 0.
- An entry matches operand r when all of these hold:
  - v and wr are set;
  - rd equals r;
  - the operand is used;
  - not (`ZERO_REG_EN` and r == 0).
- For each operand, the youngest matching stage (smallest k) wins.
  - If the winner has ld=1 and k < `LOAD_READY_STAGE`, it is a load-use hazard.
  - Otherwise `fwd_selN` = k.
  - With no match, `fwd_selN` = 0.
- `id_stall` = `id_valid` & (hazard on rs1 | hazard on rs2). Its value does not depend on `hold` or `flush`.
- `id_accept` = `id_valid` & !`id_stall` & !`hold` & !`flush`.
- Shift on each rising edge when `hold`=0:
  - entry 1 ← {1, `id_wr_en`, `id_rd`, `id_is_load`} if `id_accept`, else a bubble;
  - entry k ← entry k-1 for k ≥ 2;
  - if `flush`=1, entry 2 ← bubble, because the EX instruction is squashed.
- When `hold`=1, every entry keeps its value. `flush` is ignored while `hold`=1.
- `stall_cnt` increments when `id_valid` & `id_stall` & !`hold`.
- `fwd_cnt` increments on `id_accept` when either `fwd_sel` is nonzero.
- Both counters stop at all-ones; they do not wrap.

## Timing
- Reset (`rst`=0, asynchronous) clears:
  - all shadow entries to bubbles;
  - both counters to 0.
- Outputs during reset: `id_stall`=0, `id_accept`=`id_valid` & !`hold` & !`flush`, `fwd_sel1`=`fwd_sel2`=0.
- Hazard and forward outputs are combinational from the current shadow state and the decode inputs, with zero latency.
- An accepted writer is visible at stage 1 on the next cycle and leaves the shadow after `PIPE_DEPTH` cycles.
- Load-use gap: a dependent instruction stalls for `LOAD_READY_STAGE`-1 cycles when it immediately follows the load.
- Consumer at decode while its producer is in writeback (stage `PIPE_DEPTH`): forward from that stage. The regfile write is not yet visible to decode.
- Reset asserted mid-stall: the stall clears at once. Pending entries are discarded; the core resets as well.

## Structure
- A shared package `pipeline_pkg` holds:
  - the shadow-entry struct;
  - the `fwd_sel` encoding constants (`FWD_REGFILE` = 0);
  - `SELW` as a function of `PIPE_DEPTH`.
- One sub-module, `hazard_match`: a combinational per-operand priority match over the shadow entries, instantiated twice. The shadow shift register and the counters stay in the top module.

## Test plan
Defaults apply unless stated.
- ALU chain: `add r3` accepted, then `sub` reading r3 the next cycle → `fwd_sel1`=1, no stall, `fwd_cnt`=1.
- Load-use: `ld r5`, then `add` reading r5 in rs2 → `id_stall`=1 for 1 cycle, then `fwd_sel2`=2, and `stall_cnt`=1.
- Writeback forward: writer to r7, two bubbles, then a reader of r7 → `fwd_sel1`=3. One cycle later → `fwd_sel1`=0.
- Priority and zero register:
  - two writers to r4 back-to-back, then a reader → `fwd_sel`=1 (the youngest wins);
  - a writer to r0, then a reader of r0 → `fwd_sel`=0 and no stall.
- Hold and flush:
  - `hold`=1 for 3 cycles with a load in stage 1 → shadow frozen, `id_accept`=0, `stall_cnt` unchanged;
  - `flush` with a writer in stage 1 → the next cycle, stage 2 is a bubble and a reader gets `fwd_sel`=0.
- Reset and saturation:
  - `CNT_WIDTH`=2 with 5 stall cycles → `stall_cnt`=3;
  - assert `rst` mid-sequence → counters 0, outputs at reset values.
